line_cache_ctrl: RTL and testbench
==================================

Name: line_cache_ctrl

Overview:
- Direct-mapped, write-back, write-allocate data cache between the core load/store port and the 128-bit line memory (4 x 32-bit beats).
- Turns 32-bit word accesses into whole-line fills and writebacks using the memory's requested/ready/reset_mem_req handshake.
- Hits complete combinationally in the request cycle; misses stall the core until the line is resident.

Parameters:
- NUM_LINES, 4, number of 128-bit lines; power of 2, >= 2; IDX = log2(NUM_LINES).
- ADDR_WIDTH, 20, core byte-address width; also the memory word-address width.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- core_req  in  1  core access request; held until core_ready
- core_we  in  1  1 = store, 0 = load
- core_addr  in  ADDR_WIDTH  byte address; bits [1:0] ignored (word-aligned only)
- core_wdata  in  32  store data
- core_rdata  out  32  load data; valid when core_ready=1
- core_ready  out  1  access completes this cycle
- invalidate  in  1  clear all valid and dirty bits, no writeback
- mem_req  out  1  drives memory requested
- mem_we  out  1  drives memory we
- mem_addr  out  ADDR_WIDTH  memory word address of line base (low 2 bits = 0)
- mem_wdata  out  128  writeback line; word 0 in [31:0]
- mem_rdata  in  128  fill line from memory rd_data_out
- mem_ready  in  1  memory ready
- mem_reset_req  out  1  drives memory reset_mem_req

Behaviour:
- Address split: offset = core_addr[3:2]; index = core_addr[4+IDX-1:4]; tag = core_addr[ADDR_WIDTH-1:4+IDX].
- Per-line storage: valid, dirty, tag, 128-bit data.
- Reset:
  - valid and dirty cleared; state IDLE; started = 0.
  - All outputs 0, except mem_reset_req = 1 while reset is high, to abort any memory transaction.
  - Reset mid-WB or mid-FILL abandons the transfer; no line is updated.
- States: IDLE, WB, FILL.
- IDLE:
  - hit = core_req && valid[index] && tag match.
  - On hit: core_ready = 1 and core_rdata = selected word, same cycle (combinational).
  - On store hit: the selected word is replaced with core_wdata and dirty is set at the clock edge.
  - Miss with victim valid && dirty -> WB. Otherwise -> FILL.
  - core_ready = 0 during a miss and in every non-IDLE state.
- WB:
  - mem_req = 1, mem_we = 1, mem_wdata = victim data.
  - mem_addr = {victim tag, index, 2'b00} as a word address, zero-extended to ADDR_WIDTH.
  - On completion: dirty cleared -> FILL.
- FILL:
  - mem_req = 1, mem_we = 0, mem_addr = {0, core tag, index, 2'b00}.
  - On completion: line data <= mem_rdata, tag written, valid = 1, dirty = 0 -> IDLE.
  - The access then hits on the next cycle.
- Completion detection:
  - The memory accepts on the first WB/FILL cycle because mem_ready is still 1.
  - The started flag sets when mem_ready = 0 is seen in WB/FILL and clears on each state entry.
  - Completion = started && mem_ready.
  - In the completion cycle mem_reset_req = 1 (combinational). This stops the memory from re-arming while mem_req is still high.
  - Otherwise mem_reset_req = 0 outside reset.
- Latency:
  - Clean miss = 1 + memory busy cycles (5) + 1 completion + 1 hit cycle = 8 cycles from request to core_ready.
  - Dirty miss adds 7 cycles.
- Core-side rules:
  - core_addr, core_we and core_wdata must stay stable while core_req = 1 and core_ready = 0.
  - The miss is resolved for the held address.
- invalidate:
  - Honoured only in IDLE; it takes priority over the same-cycle access, which gets core_ready = 0.
  - Dirty data is discarded.
  - Ignored in WB/FILL.
- No core_req in IDLE: no memory activity; mem_req = 0.
- Unknown state encodings return to IDLE.

Test Plan:
- Reset, then load 0x00010 with memory holding line 0x00004 = {0x4444, 0x3333, 0x2222, 0x1111}:
  - one FILL with mem_addr = 0x00004, mem_we = 0;
  - mem_reset_req pulses once at completion;
  - core_ready 8 cycles after request with core_rdata = 0x1111.
- Load 0x00014 after that fill -> core_ready the same cycle, core_rdata = 0x2222, mem_req stays 0.
- Store 0xDEADBEEF to 0x00018 (hit), then load 0x00018 -> 0xDEADBEEF; no memory traffic; dirty set.
- Load 0x00058 (same index 1, different tag, dirty victim):
  - WB first, with mem_addr = 0x00004, mem_we = 1, and mem_wdata[95:64] = 0xDEADBEEF;
  - then FILL with mem_addr = 0x00014;
  - core_ready after 15 cycles.
- Assert reset during the 3rd busy cycle of a FILL:
  - mem_req = 0 and mem_reset_req = 1 next edge;
  - line stays invalid;
  - a re-issued load performs a full FILL.
- invalidate in IDLE with a dirty line present:
  - all lines invalid, no WB issued;
  - a subsequent load to the previously dirty address does a FILL only (mem_we never 1).

Source files
------------

// File: rtl/line_cache_ctrl.sv
// Direct-mapped write-back/write-allocate cache: hits answer combinationally in the request cycle,
// misses stall the core (core_ready=0) through an optional line writeback and a line fill.
module line_cache_ctrl #(
    parameter int NUM_LINES  = 4,
    parameter int ADDR_WIDTH = 20
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  core_req,
    input  logic                  core_we,
    input  logic [ADDR_WIDTH-1:0] core_addr,
    input  logic [31:0]           core_wdata,
    output logic [31:0]           core_rdata,
    output logic                  core_ready,
    input  logic                  invalidate,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [127:0]          mem_wdata,
    input  logic [127:0]          mem_rdata,
    input  logic                  mem_ready,
    output logic                  mem_reset_req
);
    localparam int IDX  = $clog2(NUM_LINES);
    localparam int TAGW = ADDR_WIDTH - 4 - IDX;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WB   = 2'd1,
        S_FILL = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic                 started_q, started_d;
    logic [NUM_LINES-1:0] valid_q, valid_d;
    logic [NUM_LINES-1:0] dirty_q, dirty_d;
    logic [TAGW-1:0]      tag_q  [NUM_LINES];
    logic [127:0]         data_q [NUM_LINES];

    logic [1:0]      offset;
    logic [IDX-1:0]  index;
    logic [TAGW-1:0] tag;
    logic            hit;
    logic            done;
    logic            fill_en;
    logic            store_en;
    logic [127:0]    store_line;
    logic            unused_addr_lsb;

    assign offset          = core_addr[3:2];
    assign index           = core_addr[4+IDX-1:4];
    assign tag             = core_addr[ADDR_WIDTH-1:4+IDX];
    assign unused_addr_lsb = ^core_addr[1:0];

    assign hit  = core_req && valid_q[index] && (tag_q[index] == tag);
    // The memory drops ready only after it has latched the request, so ready seen high
    // again after a low phase marks the end of the transfer.
    assign done = started_q && mem_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            started_q <= 1'b0;
            valid_q   <= '0;
            dirty_q   <= '0;
        end else begin
            state_q   <= state_d;
            started_q <= started_d;
            valid_q   <= valid_d;
            dirty_q   <= dirty_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && fill_en) begin
            tag_q[index]  <= tag;
            data_q[index] <= mem_rdata;
        end else if (!reset && store_en) begin
            data_q[index] <= store_line;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (core_req && !invalidate && !hit) begin
                    state_d = (valid_q[index] && dirty_q[index]) ? S_WB : S_FILL;
                end
            end
            S_WB:    if (done) state_d = S_FILL;
            S_FILL:  if (done) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        started_d = started_q;
        if (state_d != state_q) begin
            started_d = 1'b0;
        end else if ((state_q == S_WB || state_q == S_FILL) && !mem_ready) begin
            started_d = 1'b1;
        end
    end

    always_comb begin
        valid_d    = valid_q;
        dirty_d    = dirty_q;
        fill_en    = 1'b0;
        store_en   = 1'b0;
        store_line = data_q[index];
        store_line[{offset, 5'b00000} +: 32] = core_wdata;
        case (state_q)
            S_IDLE: begin
                if (invalidate) begin
                    valid_d = '0;
                    dirty_d = '0;
                end else if (hit && core_we) begin
                    store_en       = 1'b1;
                    dirty_d[index] = 1'b1;
                end
            end
            S_WB: if (done) dirty_d[index] = 1'b0;
            S_FILL: begin
                if (done) begin
                    fill_en        = 1'b1;
                    valid_d[index] = 1'b1;
                    dirty_d[index] = 1'b0;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        core_ready    = 1'b0;
        core_rdata    = '0;
        mem_req       = 1'b0;
        mem_we        = 1'b0;
        mem_addr      = '0;
        mem_wdata     = '0;
        mem_reset_req = 1'b0;
        if (reset) begin
            mem_reset_req = 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (hit && !invalidate) begin
                        core_ready = 1'b1;
                        core_rdata = data_q[index][{offset, 5'b00000} +: 32];
                    end
                end
                S_WB: begin
                    mem_req       = 1'b1;
                    mem_we        = 1'b1;
                    mem_wdata     = data_q[index];
                    mem_addr      = {2'b00, tag_q[index], index, 2'b00};
                    mem_reset_req = done;
                end
                S_FILL: begin
                    mem_req       = 1'b1;
                    mem_addr      = {2'b00, tag, index, 2'b00};
                    mem_reset_req = done;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_line_cache_ctrl.sv
// Scoreboarded bench for line_cache_ctrl with a 5-busy-cycle line memory model.
module tb_line_cache_ctrl;
    localparam int AW = 20;

    logic          clk = 1'b0;
    logic          reset;
    logic          core_req;
    logic          core_we;
    logic [AW-1:0] core_addr;
    logic [31:0]   core_wdata;
    logic [31:0]   core_rdata;
    logic          core_ready;
    logic          invalidate;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [127:0]  mem_wdata;
    logic [127:0]  mem_rdata;
    logic          mem_ready;
    logic          mem_reset_req;

    always #5 clk = ~clk;

    line_cache_ctrl #(.NUM_LINES(4), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .reset(reset),
        .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
        .core_wdata(core_wdata), .core_rdata(core_rdata), .core_ready(core_ready),
        .invalidate(invalidate),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .mem_reset_req(mem_reset_req)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Line memory model, indexed by line word address bits [7:2]
    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [127:0]  wdata;
    } mtxn_t;

    logic [127:0]  mem_arr [64];
    int            busy_cnt = 0;
    logic [AW-1:0] lat_addr = '0;
    int            accepts  = 0;
    mtxn_t         exp_mem_q[$];
    mtxn_t         e;

    assign mem_ready = (busy_cnt == 0);
    assign mem_rdata = mem_arr[lat_addr[7:2]];

    always @(posedge clk) begin
        if (mem_reset_req) begin
            busy_cnt <= 0;
        end else if (mem_req && mem_ready) begin
            accepts++;
            busy_cnt <= 5;
            lat_addr <= mem_addr;
            if (mem_we) mem_arr[mem_addr[7:2]] = mem_wdata;
            if (exp_mem_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL mem_unexpected: we=%0b addr=%0h expected no transaction", mem_we, mem_addr);
            end else begin
                e = exp_mem_q.pop_front();
                check("mem_we", {127'd0, mem_we}, {127'd0, e.we});
                check("mem_addr", {108'd0, mem_addr}, {108'd0, e.addr});
                if (e.we) check("mem_wdata", mem_wdata, e.wdata);
            end
        end else if (busy_cnt > 0) begin
            busy_cnt <= busy_cnt - 1;
        end
    end

    // Load-data monitor
    logic [31:0] exp_rd_q[$];
    int          rst_pulses = 0;

    always @(negedge clk) begin
        if (!reset && mem_reset_req) rst_pulses++;
        if (core_ready && core_req && !core_we) begin
            if (exp_rd_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rd_unexpected: got %0h expected no load", core_rdata);
            end else begin
                check("core_rdata", {96'd0, core_rdata}, {96'd0, exp_rd_q.pop_front()});
            end
        end
    end

    task automatic push_mem(input logic we, input logic [AW-1:0] addr, input logic [127:0] wd);
        mtxn_t t;
        t.we = we;
        t.addr = addr;
        t.wdata = wd;
        exp_mem_q.push_back(t);
    endtask

    // Called just after a rising edge; returns just after the edge that completes the access.
    task automatic access(input string name, input logic we, input logic [AW-1:0] addr,
                          input logic [31:0] wd, input logic [31:0] exp_rd, input int exp_lat);
        int lat = 0;
        bit got = 1'b0;
        core_req   = 1'b1;
        core_we    = we;
        core_addr  = addr;
        core_wdata = wd;
        if (!we) exp_rd_q.push_back(exp_rd);
        while (!got && lat <= 60) begin
            @(negedge clk);
            if (core_ready) got = 1'b1;
            else begin
                lat++;
                @(posedge clk);
            end
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got no core_ready expected ready after %0d cycles", name, exp_lat);
        end else begin
            check({name, "_lat"}, 128'(lat), 128'(exp_lat));
            if (exp_lat == 0) check({name, "_no_mem_req"}, {127'd0, mem_req}, 128'd0);
        end
        @(posedge clk);
        #1;
        core_req = 1'b0;
        core_we  = 1'b0;
    endtask

    int a0;

    initial begin
        for (int i = 0; i < 64; i++) mem_arr[i] = '0;
        mem_arr[1] = {32'h4444, 32'h3333, 32'h2222, 32'h1111};  // line 0x04
        mem_arr[2] = {32'hA003, 32'hA002, 32'hA001, 32'hA000};  // line 0x08
        mem_arr[3] = {32'hB003, 32'hB002, 32'hB001, 32'hB000};  // line 0x0C
        mem_arr[5] = {32'h8888, 32'h7777, 32'h6666, 32'h5555};  // line 0x14

        reset = 1'b1; core_req = 1'b0; core_we = 1'b0; core_addr = '0;
        core_wdata = '0; invalidate = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_mem_reset_req", {127'd0, mem_reset_req}, 128'd1);
        check("rst_mem_req", {127'd0, mem_req}, 128'd0);
        check("rst_mem_we", {127'd0, mem_we}, 128'd0);
        check("rst_core_ready", {127'd0, core_ready}, 128'd0);
        check("rst_mem_addr", {108'd0, mem_addr}, 128'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("idle_mem_reset_req", {127'd0, mem_reset_req}, 128'd0);
        check("idle_mem_req", {127'd0, mem_req}, 128'd0);
        @(posedge clk); #1;

        // Clean miss
        rst_pulses = 0;
        push_mem(1'b0, 20'h00004, '0);
        access("fill_load", 1'b0, 20'h00010, '0, 32'h1111, 8);
        check("fill_reset_pulses", 128'(rst_pulses), 128'd1);

        // Hits: no memory traffic
        a0 = accepts;
        access("hit_load", 1'b0, 20'h00014, '0, 32'h2222, 0);
        access("hit_store", 1'b1, 20'h00018, 32'hDEADBEEF, '0, 0);
        access("hit_reload", 1'b0, 20'h00018, '0, 32'hDEADBEEF, 0);
        check("hit_accepts", 128'(accepts), 128'(a0));

        // Dirty conflict miss: writeback then fill
        push_mem(1'b1, 20'h00004, {32'h4444, 32'hDEADBEEF, 32'h2222, 32'h1111});
        push_mem(1'b0, 20'h00014, '0);
        access("dirty_miss", 1'b0, 20'h00058, '0, 32'h7777, 15);

        // Reset in the 3rd busy cycle of a fill
        push_mem(1'b0, 20'h00008, '0);
        core_req = 1'b1; core_we = 1'b0; core_addr = 20'h00020;
        repeat (4) @(posedge clk);
        #1;
        reset = 1'b1;
        core_req = 1'b0;
        @(negedge clk);
        check("abort_mem_req", {127'd0, mem_req}, 128'd0);
        check("abort_mem_reset_req", {127'd0, mem_reset_req}, 128'd1);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk); #1;
        push_mem(1'b0, 20'h00008, '0);
        access("refill_after_reset", 1'b0, 20'h00020, '0, 32'hA000, 8);

        // Invalidate with a dirty line present
        push_mem(1'b0, 20'h0000C, '0);
        access("fill_idx3", 1'b0, 20'h00030, '0, 32'hB000, 8);
        access("dirty_store", 1'b1, 20'h00024, 32'hCAFEF00D, '0, 0);
        core_req = 1'b1; core_we = 1'b0; core_addr = 20'h00024; invalidate = 1'b1;
        @(negedge clk);
        check("inval_priority_ready", {127'd0, core_ready}, 128'd0);
        @(posedge clk); #1;
        invalidate = 1'b0;
        push_mem(1'b0, 20'h00008, '0);
        access("post_inval_load", 1'b0, 20'h00024, '0, 32'hA001, 8);
        push_mem(1'b0, 20'h0000C, '0);
        access("post_inval_idx3", 1'b0, 20'h00030, '0, 32'hB000, 8);

        repeat (3) @(posedge clk);
        check("mem_queue_empty", 128'(exp_mem_q.size()), 128'd0);
        check("rd_queue_empty", 128'(exp_rd_q.size()), 128'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no end of test expected finish before 100000");
        $fatal(1);
    end
endmodule
